// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request outstanding and hands words to decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and pulse fetch_misaligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_taken,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_misaligned
);

  localparam int unsigned XLEN = 32;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {S_RESET, S_REQ, S_WAIT, S_DRAIN, S_HOLD, S_HALT} state_e;
`else
  typedef enum logic [2:0] {S_RESET, S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_e;
`endif

  state_e            state_q, state_d;
  state_e            after_redirect;
  state_e            resume_st;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_data_q, inst_data_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              req_valid_q;
  logic              inst_valid_q;
  logic              redirect_act;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic              halt_pend_q, halt_pend_d;
  logic              mis_q, mis_d;
  logic              bad_target;
  assign bad_target = |redirect_target[1:0];
  // A drained flush resumes into HALT when the redirect that caused it was misaligned.
  assign resume_st  = halt_pend_q ? S_HALT : S_REQ;
`else
  logic              unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];
  assign resume_st          = S_REQ;
`endif

  assign redirect_act = redirect_taken && (state_q != S_RESET);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_data_d    = inst_data_q;
    inst_pc_d      = inst_pc_q;
    after_redirect = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
    halt_pend_d    = halt_pend_q;
    mis_d          = 1'b0;
`endif
    unique case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_data_d = imem_rsp_data;
          inst_pc_d   = pc_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
      S_DRAIN: if (imem_rsp_valid) state_d = resume_st;
`ifdef FETCH_MISALIGN_CHECK_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_RESET;
    endcase

    // Redirect overrides every other update and discards any capture made this cycle.
    if (redirect_act) begin
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_pend_d = bad_target;
      mis_d       = bad_target;
      if (!bad_target) pc_d = redirect_target;
      after_redirect = bad_target ? S_HALT : S_REQ;
`else
      pc_d = {redirect_target[XLEN-1:2], 2'b00};
`endif
      unique case (state_q)
        S_REQ:   state_d = imem_req_ready ? S_DRAIN : after_redirect;
        S_WAIT:  state_d = imem_rsp_valid ? after_redirect : S_DRAIN;
        S_DRAIN: state_d = imem_rsp_valid ? after_redirect : S_DRAIN;
        default: state_d = after_redirect;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_pend_q  <= 1'b0;
      mis_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= (state_d == S_REQ);
      inst_valid_q <= (state_d == S_HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_pend_q  <= halt_pend_d;
      mis_q        <= mis_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misaligned = mis_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change 1ns after the rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_taken;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_taken(redirect_taken), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_taken = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1;
    tick(); tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h100) begin n_errors++; $display("FAIL rst_req_addr got %h exp 00000100", imem_req_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
    n_checks++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_errors++; $display("FAIL rst_inst got data %h pc %h exp 0 0", inst_data, inst_pc); end
    n_checks++; if (fetch_misaligned !== 1'b0) begin n_errors++; $display("FAIL rst_misaligned got %b exp 0", fetch_misaligned); end
    rst_n = 1'b1;
    #2;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_state_req got %b exp 0", imem_req_valid); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_errors++; $display("FAIL first_req got v%b %h exp v1 00000100", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    for (int k = 0; k < 3; k++) begin
      exp_pc   = 32'h100 + 32'(4 * k);
      exp_data = 32'(8'h11 * (k + 1));
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL seq_req%0d got v%b %h exp v1 %h", k, imem_req_valid, imem_req_addr, exp_pc); end
      tick();
      n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL seq_wait%0d got req %b inst %b exp 0 0", k, imem_req_valid, inst_valid); end
      imem_rsp_valid = 1'b1; imem_rsp_data = exp_data;
      tick();
      imem_rsp_valid = 1'b0;
      n_checks++; if (inst_valid !== 1'b1 || inst_data !== exp_data || inst_pc !== exp_pc) begin n_errors++; $display("FAIL seq_hold%0d got v%b %h @%h exp v1 %h @%h", k, inst_valid, inst_data, inst_pc, exp_data, exp_pc); end
      tick();
      n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL seq_after%0d inst_valid got %b exp 0", k, inst_valid); end
    end
  endtask

  task automatic test_backpressure();
    n_checks++; if (imem_req_addr !== 32'h10C) begin n_errors++; $display("FAIL bp_req got %h exp 0000010c", imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h44; inst_ready = 1'b0;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h99;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst_data !== 32'h44 || inst_pc !== 32'h10C || imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_hold%0d got v%b %h @%h req %b exp v1 00000044 @0000010c req 0", i, inst_valid, inst_data, inst_pc, imem_req_valid); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release got v%b %h inst %b exp v1 00000110 inst 0", imem_req_valid, imem_req_addr, inst_valid); end
  endtask

  task automatic test_redirect_wait();
    tick();
    redirect_taken = 1'b1; redirect_target = 32'h200;
    tick();
    redirect_taken = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h200) begin n_errors++; $display("FAIL rw_drain got v%b %h exp v0 00000200", imem_req_valid, imem_req_addr); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD;
    tick();
    imem_rsp_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h44) begin n_errors++; $display("FAIL rw_discard got v%b %h exp v0 00000044", inst_valid, inst_data); end
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_errors++; $display("FAIL rw_refetch got v%b %h exp v1 00000200", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_hold();
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55;
    tick();
    imem_rsp_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_data !== 32'h55 || inst_pc !== 32'h200) begin n_errors++; $display("FAIL rh_hold got v%b %h @%h exp v1 00000055 @00000200", inst_valid, inst_data, inst_pc); end
    inst_ready = 1'b1; redirect_taken = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_taken = 1'b0; imem_req_ready = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL rh_target got v%b %h inst %b exp v1 00000300 inst 0", imem_req_valid, imem_req_addr, inst_valid); end
    tick();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_addr !== 32'h300) begin n_errors++; $display("FAIL rh_once got inst %b addr %h exp 0 00000300", inst_valid, imem_req_addr); end
  endtask

  task automatic test_misalign();
    redirect_taken = 1'b1; redirect_target = 32'h402;
    tick();
    redirect_taken = 1'b0; imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++; if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_pulse got mis %b req %b exp 1 0", fetch_misaligned, imem_req_valid); end
    tick();
    n_checks++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_halt1 got mis %b req %b exp 0 0", fetch_misaligned, imem_req_valid); end
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL mis_halt2 got req %b exp 0", imem_req_valid); end
`else
    n_checks++; if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin n_errors++; $display("FAIL mis_off got mis %b v%b %h exp 0 v1 00000400", fetch_misaligned, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b0;
`endif
    redirect_taken = 1'b1; redirect_target = 32'h400;
    tick();
    redirect_taken = 1'b0; imem_req_ready = 1'b1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400 || fetch_misaligned !== 1'b0) begin n_errors++; $display("FAIL mis_aligned got v%b %h mis %b exp v1 00000400 0", imem_req_valid, imem_req_addr, fetch_misaligned); end
  endtask

  task automatic test_reset_midop();
    tick();
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL mid_wait got req %b exp 0", imem_req_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req_addr !== 32'h100 || inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset got %h %h @%h v%b exp 00000100 0 @0 v0", imem_req_addr, inst_data, inst_pc, inst_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL mid_restart got v%b %h inst %b exp v1 00000100 inst 0", imem_req_valid, imem_req_addr, inst_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
